sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised synchronous FIFO, the next-generation buffer for single-clock datapaths. It adds configurable width and depth (any depth ≥ 2, not limited to powers of two) and an occupancy count output. It also provides programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a read-valid strobe. Status flags always reflect the current occupancy, with no one-cycle lag.

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of storage entries; legal range ≥ 2, any integer.
- AF_LEVEL, 14: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- clr  in  1  synchronous flush; empties the FIFO and clears error flags.
- w_en  in  1  write request.
- data_in  in  WIDTH  write data.
- r_en  in  1  read request.
- data_out  out  WIDTH  registered read data.
- rd_valid  out  1  high for one cycle when data_out was updated by an accepted read.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- Storage: DEPTH × WIDTH array. Memory contents are not reset.
- Pointers:
  - w_ptr and r_ptr are $clog2(DEPTH) bits wide.
  - Each wraps from DEPTH-1 to 0 by explicit compare, never by natural overflow.
- Accept rules, evaluated on current (pre-edge) state:
  - wr_acc = w_en & (!full | r_en).
  - rd_acc = r_en & !empty.
  - A write while full is accepted only together with a read; count stays DEPTH.
  - A read while empty is rejected even if a write occurs in the same cycle.
- Count update:
  - +1 when wr_acc & !rd_acc.
  - −1 when rd_acc & !wr_acc.
  - Unchanged when both or neither are accepted.
- Flags (full, empty, almost_full, almost_empty):
  - Decoded from the count register, or registered from next-count; either way they must match count in the same cycle.
  - A write into an empty FIFO is visible as empty=0 on the next cycle.
- Accepted read: data_out ← mem[r_ptr]. When a read and a write target the same entry in one cycle, old data is read (write-then-read ordering is not permitted).
- No accepted read: data_out holds its value and rd_valid = 0.
- Error flags:
  - overflow sets on w_en & full & !r_en.
  - underflow sets on r_en & empty.
  - Both stay set until clr or reset.
- clr (synchronous, highest priority over w_en/r_en):
  - Pointers and count go to 0; overflow, underflow and rd_valid go to 0.
  - data_out holds its value.
- Reset values (asynchronous on rst = 0):
  - data_out = 0, rd_valid = 0, count = 0.
  - empty = 1, full = 0, almost_full = 0, almost_empty = 1.
  - overflow = 0, underflow = 0; both pointers = 0.
- Reset mid-operation: all in-flight state is discarded; the FIFO is empty after reset release.

## Timing
- Write-to-read availability: a word written at edge N can be read with r_en high in cycle N+1; data_out and rd_valid are valid after edge N+1.
- Read latency: 1 cycle from the r_en sampling edge to data_out/rd_valid.
- Throughput: 1 write and 1 read per cycle sustained, including at full and empty boundaries as defined above.
- rst is asynchronous on assertion. Deassertion is assumed synchronised upstream; the first accepted operation is on the first edge with rst = 1.

## Test plan
- Reset, then write 16 words 0x00..0x0F (DEPTH=16) -> full=1, count=16, almost_full first high after the 14th write. A 17th write -> rejected, overflow=1, count stays 16.
- From full, read all 16 words -> data_out sequence 0x00..0x0F, rd_valid high for 16 cycles, empty=1, almost_empty high once count ≤ 2. An extra read -> underflow=1, rd_valid=0, data_out holds 0x0F.
- Simultaneous read+write at full (count=16) -> both accepted, count stays 16, full stays 1, overflow stays 0. Simultaneous read+write at empty -> write accepted, read rejected, underflow=1, count=1.
- Wrap-around with DEPTH=5: run 23 streaming write/read pairs with values 0xA0+i -> data ordering preserved across pointer wrap, count never exceeds 5.
- Assert clr with count=7 and overflow=1 -> next cycle count=0, empty=1, overflow=0, and data_out unchanged.
- Assert rst low asynchronously mid-stream (count=9, between clock edges) -> all outputs immediately take their reset values; after release, the first write/read returns the newly written data.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param - single-clock FIFO with configurable width and depth.
//
// Depth may be any value >= 2. Pointers wrap from DEPTH-1 back to 0 by an
// explicit compare, so depths that are not a power of two are handled.
// Occupancy is kept in a dedicated count register. All status flags are
// decoded directly from that register, so they never lag the count.
//
// Parameters:
//   WIDTH    - data word width in bits
//   DEPTH    - number of storage entries (>= 2)
//   AF_LEVEL - almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL - almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk          in   clock; all state changes on its rising edge
//   rst          in   asynchronous reset, active low
//   clr          in   synchronous flush; empties the FIFO and clears error
//                     flags. Takes priority over w_en/r_en
//   w_en         in   write request
//   data_in      in   write data
//   r_en         in   read request
//   data_out     out  registered read data; holds when no read is accepted
//   rd_valid     out  one-cycle strobe: data_out was updated by a read
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  current occupancy, 0..DEPTH
//   overflow     out  sticky: a write was rejected
//   underflow    out  sticky: a read was rejected
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         w_en,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         r_en,
    output logic [WIDTH-1:0]             data_out,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    // Wrap by compare so non-power-of-two depths never address past DEPTH-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    w_ptr_q, w_ptr_d;
    logic [PW-1:0]    r_ptr_q, r_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic full_s, empty_s;
    logic wr_acc, rd_acc;

    // Status decode from the count register (no lag relative to count).
    always_comb begin
        full_s  = (count_q == CNT_FULL);
        empty_s = (count_q == '0);
        // A write while full is legal only alongside a read, which is then
        // always accepted because a full FIFO (DEPTH >= 2) is never empty.
        wr_acc  = w_en & (~full_s | r_en);
        rd_acc  = r_en & ~empty_s;
    end

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr) begin
            w_ptr_d     = '0;
            r_ptr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr_d = ptr_inc(w_ptr_q);
            end
            if (rd_acc) begin
                r_ptr_d    = ptr_inc(r_ptr_q);
                // Array is read before the same-edge write lands, so a
                // read/write to the same entry returns the old word.
                data_out_d = mem_q[r_ptr_q];
                rd_valid_d = 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CNT_ONE;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CNT_ONE;
            end
            if (w_en && full_s && !r_en) begin
                overflow_d = 1'b1;
            end
            if (r_en && empty_s) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Storage has no reset; flush suppresses the write on that edge.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) begin
            mem_q[w_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign data_out     = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
